// File: rtl/uart_hex_sender.sv
// uart_hex_sender: sends a captured 64-bit dump as ASCII hex plus CR LF over valid/ready; define MON_HEX_SEP_EN to add a space between the two words
module uart_hex_sender #(
  parameter bit UPPER_HEX = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdata_snd_start,
  input  logic [63:0] rdata_snd,
  input  logic        snd_abort,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        flushing_wq,
  output logic        snd_busy
);
`ifdef MON_HEX_SEP_EN
  localparam logic [4:0] LAST = 5'd18;
`else
  localparam logic [4:0] LAST = 5'd17;
`endif
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;
  state_t      state;
  logic [63:0] sr, sr_nx;
  logic [4:0]  cnt, cnt_nx;
  logic        abort_q, accept;
  function automatic logic is_hex(input logic [4:0] i);
`ifdef MON_HEX_SEP_EN
    return i < 5'd17 && i != 5'd8;
`else
    return i < 5'd16;
`endif
  endfunction
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + 8'(n) : (UPPER_HEX ? 8'h37 : 8'h57) + 8'(n);
  endfunction
  function automatic logic [7:0] char_at(input logic [4:0] i, input logic [3:0] n);
    return is_hex(i) ? hex_char(n) : i == LAST ? 8'h0a : i == LAST - 5'd1 ? 8'h0d : 8'h20;
  endfunction
  assign accept = tx_valid & tx_ready;
  assign cnt_nx = cnt + 5'd1;
  assign sr_nx  = is_hex(cnt) ? {sr[59:0], 4'h0} : sr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      sr          <= '0;
      cnt         <= '0;
      abort_q     <= 1'b0;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
      flushing_wq <= 1'b0;
      snd_busy    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          abort_q <= 1'b0;
          if (rdata_snd_start) begin
            state    <= S_SEND;
            sr       <= rdata_snd;
            cnt      <= '0;
            tx_data  <= hex_char(rdata_snd[63:60]);
            tx_valid <= 1'b1;
            snd_busy <= 1'b1;
          end
        end
        S_SEND: begin
          if (accept) begin
            if (abort_q || snd_abort) begin
              state    <= S_IDLE;
              tx_valid <= 1'b0;
              tx_data  <= 8'h00;
              snd_busy <= 1'b0;
              abort_q  <= 1'b0;
            end else if (cnt == LAST) begin
              state       <= S_DONE;
              tx_valid    <= 1'b0;
              tx_data     <= 8'h00;
              flushing_wq <= 1'b1;
            end else begin
              sr      <= sr_nx;
              cnt     <= cnt_nx;
              tx_data <= char_at(cnt_nx, sr_nx[63:60]);
            end
          end else if (snd_abort) begin
            abort_q <= 1'b1;
          end
        end
        S_DONE: begin
          state       <= S_IDLE;
          flushing_wq <= 1'b0;
          snd_busy    <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_hex_sender.sv
// tb_uart_hex_sender: table vectors, randomized lines with backpressure, abort and reset sequences
module tb_uart_hex_sender;
`ifdef MON_HEX_SEP_EN
  localparam int L = 19;
  localparam bit SEP = 1'b1;
`else
  localparam int L = 18;
  localparam bit SEP = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, tx_ready = 1'b0;
  logic [63:0] rdata = '0;
  logic [7:0]  d_u, d_l;
  logic        v_u, v_l, f_u, f_l, b_u, b_l;
  int          checks = 0, errors = 0;
  byte unsigned exp_q[$];
  typedef struct {
    logic [63:0] p;
    int          pct;
    bit          lc;
    int          inj;
    string       txt;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  uart_hex_sender #(.UPPER_HEX(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .rdata_snd_start(start), .rdata_snd(rdata), .snd_abort(abort),
    .tx_data(d_u), .tx_valid(v_u), .tx_ready(tx_ready), .flushing_wq(f_u), .snd_busy(b_u));
  uart_hex_sender #(.UPPER_HEX(1'b0)) dut_lc (
    .clk(clk), .rst_n(rst_n), .rdata_snd_start(start), .rdata_snd(rdata), .snd_abort(abort),
    .tx_data(d_l), .tx_valid(v_l), .tx_ready(tx_ready), .flushing_wq(f_l), .snd_busy(b_l));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic void from_text(input string s);
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      if (SEP && i == 8) exp_q.push_back(8'h20);
      exp_q.push_back(8'(s[i]));
    end
    exp_q.push_back(8'h0d);
    exp_q.push_back(8'h0a);
  endfunction

  function automatic void model(input logic [63:0] p, input bit upper);
    int nib;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      if (SEP && i == 8) exp_q.push_back(8'h20);
      nib = int'((p >> (60 - 4 * i)) & 64'hF);
      exp_q.push_back(8'(nib < 10 ? int'("0") + nib : (upper ? int'("A") : int'("a")) + nib - 10));
    end
    exp_q.push_back(8'h0d);
    exp_q.push_back(8'h0a);
  endfunction

  task automatic run_line(input string nm, input logic [63:0] p, input int pct, input bit lc, input int inj);
    byte unsigned got[$];
    int   flushes = 0, tf = 0, unstable = 0, bdrop = 0, t = 0, mism = 0;
    bit   pv = 1'b0, pr = 1'b0, done = 1'b0, injected = 1'b0, first_v = 1'b0;
    logic [7:0] pd = '0, d;
    logic v, f, b;
    rdata = p;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && t < 2000) begin
      t++;
      v = lc ? v_l : v_u;
      d = lc ? d_l : d_u;
      f = lc ? f_l : f_u;
      b = lc ? b_l : b_u;
      if (t == 1) first_v = v;
      if (pv && !pr && (!v || d !== pd)) unstable++;
      if (tf == 0 && !b) bdrop++;
      if (f) begin
        flushes++;
        tf = t;
      end
      if (tf != 0 && t == tf + 1) begin
        chk({nm, " busy_after_flush"}, {63'd0, b}, 64'd0);
        done = 1'b1;
      end
      tx_ready = ($urandom_range(99) < pct);
      if (inj >= 0 && !injected && v && got.size() == inj) begin
        start = 1'b1;
        rdata = 64'hDEADBEEF_00000000;
        injected = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (v && tx_ready && !done) got.push_back(d);
      pv = v;
      pr = tx_ready;
      pd = d;
      if (!done) @(negedge clk);
    end
    start = 1'b0;
    tx_ready = 1'b0;
    chk({nm, " timeout"}, {63'd0, done}, 64'd1);
    chk({nm, " first_valid"}, {63'd0, first_v}, 64'd1);
    chk({nm, " length"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] != exp_q[i]) mism++;
    chk({nm, " bytes_wrong"}, mism, 0);
    chk({nm, " flush_pulses"}, flushes, 1);
    chk({nm, " unstable_stall"}, unstable, 0);
    chk({nm, " busy_dropped"}, bdrop, 0);
    if (pct == 100) chk({nm, " flush_cycle"}, tf, L + 1);
  endtask

  initial begin
    int flush_cnt;
    logic [63:0] p;
    bit lc;
    vecs[0] = '{64'h0123456789ABCDEF, 100, 1'b0, -1, "0123456789ABCDEF"};
    vecs[1] = '{64'hFFFFFFFFA5A5A5A5, 100, 1'b1, -1, "ffffffffa5a5a5a5"};
    vecs[2] = '{64'h0123456789ABCDEF, 50, 1'b0, -1, "0123456789ABCDEF"};
    vecs[3] = '{64'h0123456789ABCDEF, 100, 1'b0, 5, "0123456789ABCDEF"};
    vecs[4] = '{64'h0000000000000000, 100, 1'b0, -1, "0000000000000000"};
    vecs[5] = '{64'hFEDCBA9876543210, 30, 1'b1, 5, "fedcba9876543210"};
    repeat (2) @(negedge clk);
    chk("reset tx_data", {56'd0, d_u}, 64'd0);
    chk("reset tx_valid", {63'd0, v_u}, 64'd0);
    chk("reset flushing_wq", {63'd0, f_u}, 64'd0);
    chk("reset snd_busy", {63'd0, b_u}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    foreach (vecs[i]) begin
      from_text(vecs[i].txt);
      run_line($sformatf("vec%0d", i), vecs[i].p, vecs[i].pct, vecs[i].lc, vecs[i].inj);
    end
    for (int i = 0; i < 8; i++) begin
      p = {$urandom, $urandom};
      lc = 1'($urandom_range(1));
      model(p, !lc);
      run_line($sformatf("rand%0d", i), p, int'($urandom_range(100, 20)), lc, -1);
    end
    // abort while stalled on char 3: held, accepted, then idle without flush
    model(64'h0123456789ABCDEF, 1'b1);
    rdata = 64'h0123456789ABCDEF;
    start = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    tx_ready = 1'b0;
    abort = 1'b1;
    chk("abort hold0", {55'd0, v_u, d_u}, {55'd0, 1'b1, exp_q[3]});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      abort = 1'b0;
      chk("abort hold", {55'd0, v_u, d_u}, {55'd0, 1'b1, exp_q[3]});
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    chk("abort busy_low", {63'd0, b_u}, 64'd0);
    chk("abort valid_low", {63'd0, v_u}, 64'd0);
    chk("abort no_flush0", {63'd0, f_u}, 64'd0);
    @(negedge clk);
    chk("abort no_flush1", {63'd0, f_u}, 64'd0);
    model(64'h0123456789ABCDEF, 1'b1);
    run_line("after_abort", 64'h0123456789ABCDEF, 100, 1'b0, -1);
    // reset asserted mid-line
    rdata = 64'h0123456789ABCDEF;
    start = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset tx_data", {56'd0, d_u}, 64'd0);
    chk("midreset tx_valid", {63'd0, v_u}, 64'd0);
    chk("midreset flushing_wq", {63'd0, f_u}, 64'd0);
    chk("midreset snd_busy", {63'd0, b_u}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    flush_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (f_u || v_u) flush_cnt++;
    end
    tx_ready = 1'b0;
    chk("midreset quiet", flush_cnt, 0);
    model(64'hA5A5A5A5_5A5A5A5A, 1'b1);
    run_line("after_reset", 64'hA5A5A5A5_5A5A5A5A, 100, 1'b0, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
